cpu_run_ctrl: RTL

Sequencer that owns the CPU's instruction memory and run control. It streams a program from a host loader into instruction RAM, then issues a one-cycle CPU reset (PC := 0). It runs the CPU with a clock enable and stops it on a jump-to-self, a cycle limit or a host abort. It sits between the host/debug interface, the instruction RAM write port and the CPU's reset/enable inputs.

---
 rtl/cpu_ctrl_pkg.sv | 21 ++
 rtl/cpu_run_ctrl_halt_detect.sv | 49 ++++
 rtl/cpu_run_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM states, halt causes and word width.
package cpu_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BOOT,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'b00,
    HALT_LOOP    = 2'b01,
    HALT_TIMEOUT = 2'b10,
    HALT_ABORT   = 2'b11
  } halt_cause_t;

endpackage

// File: rtl/cpu_run_ctrl_halt_detect.sv
// Watches the CPU program counter while running and reports the highest-priority
// reason to stop: host abort, jump-to-self, or exhausting the cycle budget.
module halt_detect
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              abort,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] cycle_count,
  output logic              hit,
  output halt_cause_t       cause
);

  logic [WORD_W-1:0] prev_pc;
  logic              loop_hit;
  logic              timeout_hit;
  logic              abort_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc <= '0;
    end else if (run) begin
      prev_pc <= pc;
    end
  end

  // prev_pc is stale on the first RUN cycle, which is exactly when cycle_count is zero
  assign loop_hit    = run && (cycle_count != '0) && (pc == prev_pc);
  assign timeout_hit = run && (cycle_count == WORD_W'(MAX_CYCLES - 1));
  assign abort_hit   = run && abort;

  always_comb begin
    cause = HALT_NONE;
    if (abort_hit) begin
      cause = HALT_ABORT;
    end else if (loop_hit) begin
      cause = HALT_LOOP;
    end else if (timeout_hit) begin
      cause = HALT_TIMEOUT;
    end
  end

  assign hit = (cause != HALT_NONE);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: streams a host program into instruction RAM, pulses a
// one-cycle CPU reset, then runs the CPU until it halts or the host intervenes.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic              abort,
  input  logic              clear,
  input  logic [WORD_W-1:0] cpu_instr_addr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [WORD_W-1:0] cycle_count
);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [WORD_W-1:0] count;
  halt_cause_t       cause_q;
  logic              beat;
  logic              run;
  logic              halt_hit;
  halt_cause_t       halt_cause_det;

  assign run  = (state == RUN);
  assign beat = load_valid && load_ready;

  halt_detect #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_halt_detect (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .abort      (abort),
    .pc         (cpu_instr_addr),
    .cycle_count(count),
    .hit        (halt_hit),
    .cause      (halt_cause_det)
  );

  // The CPU is held in reset whenever no program is running or done
  assign load_ready  = (state == IDLE) || (state == LOAD);
  assign cpu_reset   = (state == IDLE) || (state == LOAD) || (state == BOOT);
  assign cpu_en      = (state == BOOT) || (state == RUN);
  assign busy        = (state == LOAD) || (state == BOOT) || (state == RUN);
  assign done        = (state == DONE);
  assign imem_we     = beat;
  assign imem_addr   = wptr;
  assign imem_wdata  = load_data;
  assign halt_cause  = cause_q;
  assign cycle_count = count;

  // wptr returns to zero whenever a load finishes or is abandoned, so IDLE always writes from 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wptr    <= '0;
      count   <= '0;
      cause_q <= HALT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (abort) begin
            wptr <= '0;
          end else if (beat) begin
            if (load_last) begin
              state <= BOOT;
              wptr  <= '0;
            end else begin
              state <= LOAD;
              wptr  <= wptr + ADDR_W'(1);
            end
          end else if (start) begin
            state <= BOOT;
          end
        end

        LOAD: begin
          if (abort) begin
            state <= IDLE;
            wptr  <= '0;
          end else if (beat) begin
            if (load_last) begin
              state <= BOOT;
              wptr  <= '0;
            end else begin
              wptr <= wptr + ADDR_W'(1);
            end
          end
        end

        BOOT: begin
          count   <= '0;
          cause_q <= HALT_NONE;
          if (abort) begin
            state   <= DONE;
            cause_q <= HALT_ABORT;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          count <= count + WORD_W'(1);
          if (halt_hit) begin
            state   <= DONE;
            cause_q <= halt_cause_det;
          end
        end

        DONE: begin
          if (clear) begin
            state   <= IDLE;
            count   <= '0;
            cause_q <= HALT_NONE;
          end else if (start) begin
            state   <= BOOT;
            count   <= '0;
            cause_q <= HALT_NONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
